// File: rtl/arashi_pkg.sv
// Shared op encoding and legality check for the arashi request scheduler.
// No logic state; pure types, constants and a combinational helper.
// Imported by the FIFO and the scheduler top.
package arashi_pkg;
  typedef logic [1:0] op_t;

  localparam op_t OP_NONE  = 2'b00;
  localparam op_t OP_READ  = 2'b01;
  localparam op_t OP_WRITE = 2'b10;

  // Only read and write reach the core; 00 and 11 are rejected at the host port.
  function automatic logic op_legal(input op_t op);
    return (op == OP_READ) || (op == OP_WRITE);
  endfunction
endpackage

// File: rtl/arashi_req_fifo.sv
// Single-thread synchronous FIFO holding {op, data} entries for one core thread.
// Latency: a push is visible at rdata the cycle after the pushing edge; level is registered.
// Backpressure: push ignored while full, pop ignored while empty; full/empty are pre-edge.
module arashi_req_fifo #(
  parameter int WIDTH   = 34,
  parameter int FIFO_AW = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [WIDTH-1:0]   wdata,
  output logic [WIDTH-1:0]   rdata,
  output logic               full,
  output logic               empty,
  output logic [FIFO_AW:0]   level
);
  localparam int DEPTH = 1 << FIFO_AW;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [FIFO_AW:0] r_wp;
  logic [FIFO_AW:0] r_rp;
  logic [FIFO_AW:0] r_level;
  logic             w_push;
  logic             w_pop;

  // Extra pointer MSB separates the full case (laps differ) from empty.
  assign full   = (r_wp[FIFO_AW] != r_rp[FIFO_AW]) &&
                  (r_wp[FIFO_AW-1:0] == r_rp[FIFO_AW-1:0]);
  assign empty  = (r_wp == r_rp);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign rdata  = r_mem[r_rp[FIFO_AW-1:0]];
  assign level  = r_level;

  // Pointer and occupancy update; simultaneous push and pop leaves level unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + (FIFO_AW+1)'(1);
      if (w_pop)  r_rp <= r_rp + (FIFO_AW+1)'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (FIFO_AW+1)'(1);
        2'b01:   r_level <= r_level - (FIFO_AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage array; contents are don't-care while the FIFO is empty, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[FIFO_AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/arashi_req_sched.sv
// Host request intake into per-thread FIFOs, issuing one registered op per thread per cycle.
// Latency: request accepted at edge k into an empty FIFO appears on ctrl after edge k+1.
// Backpressure: req_ready = !full[req_tid] (pre-pop); stall freezes all FIFOs and zeroes ctrl.
module arashi_req_sched
  import arashi_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int THREAD_NUM_WIDTH = 2,
  parameter int FIFO_AW          = 2
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        req_valid,
  output logic                                        req_ready,
  input  logic [THREAD_NUM_WIDTH-1:0]                 req_tid,
  input  logic [1:0]                                  req_op,
  input  logic [DATA_WIDTH-1:0]                       req_data,
  output logic                                        req_err,
  input  logic                                        stall,
  output logic [2*(1<<THREAD_NUM_WIDTH)-1:0]          ctrl,
  output logic [DATA_WIDTH*(1<<THREAD_NUM_WIDTH)-1:0] data_in,
  output logic [(FIFO_AW+1)*(1<<THREAD_NUM_WIDTH)-1:0] level
);
  localparam int THREAD_NUM = 1 << THREAD_NUM_WIDTH;
  localparam int PW         = DATA_WIDTH + 2;

  if (THREAD_NUM_WIDTH < 2 || THREAD_NUM_WIDTH > 4) begin : g_bad_tnw
    $error("arashi_req_sched: THREAD_NUM_WIDTH must be within 2..4");
  end
  if (FIFO_AW < 1 || FIFO_AW > 4) begin : g_bad_aw
    $error("arashi_req_sched: FIFO_AW must be within 1..4");
  end

  logic [THREAD_NUM-1:0] w_full;
  logic [THREAD_NUM-1:0] w_empty;
  logic [THREAD_NUM-1:0] w_push;
  logic [THREAD_NUM-1:0] w_pop;
  logic [PW-1:0]         w_rdata [THREAD_NUM];
  logic                  w_acc;
  logic                  w_legal;

  logic [2*THREAD_NUM-1:0]          r_ctrl;
  logic [DATA_WIDTH*THREAD_NUM-1:0] r_data;
  logic                             r_err;

  assign req_ready = !w_full[req_tid];
  assign w_acc     = req_valid && req_ready;
  assign w_legal   = op_legal(op_t'(req_op));

  for (genvar t = 0; t < THREAD_NUM; t++) begin : g_thr
    assign w_push[t] = w_acc && w_legal && (req_tid == THREAD_NUM_WIDTH'(t));
    assign w_pop[t]  = !stall && !w_empty[t];

    arashi_req_fifo #(
      .WIDTH   (PW),
      .FIFO_AW (FIFO_AW)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push[t]),
      .pop   (w_pop[t]),
      .wdata ({req_op, req_data}),
      .rdata (w_rdata[t]),
      .full  (w_full[t]),
      .empty (w_empty[t]),
      .level (level[t*(FIFO_AW+1) +: (FIFO_AW+1)])
    );
  end

  // Issue registers: drive the popped head, otherwise idle ctrl and hold data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl <= '0;
      r_data <= '0;
    end else begin
      for (int t = 0; t < THREAD_NUM; t++) begin
        if (w_pop[t]) begin
          r_ctrl[2*t +: 2]                 <= w_rdata[t][DATA_WIDTH +: 2];
          r_data[t*DATA_WIDTH +: DATA_WIDTH] <= w_rdata[t][DATA_WIDTH-1:0];
        end else begin
          r_ctrl[2*t +: 2] <= OP_NONE;
        end
      end
    end
  end

  // One-cycle error pulse for each accepted-but-dropped illegal op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= w_acc && !w_legal;
  end

  assign ctrl    = r_ctrl;
  assign data_in = r_data;
  assign req_err = r_err;
endmodule
